// File: rtl/mod_n_seq_checker_if.sv
// mod_n_seq_checker_if: sample bus and status outputs of the mod-N sequence checker
interface mod_n_seq_checker_if #(
  parameter int WIDTH      = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8
);
  logic                  en;
  logic [WIDTH-1:0]      cnt_in;
  logic                  clr;
  logic                  locked;
  logic                  err_pulse;
  logic                  range_err;
  logic [ERR_CNT_W-1:0]  err_count;
  logic [WRAP_CNT_W-1:0] wrap_count;
  logic [1:0]            state;
  modport master (output en, cnt_in, clr, input locked, err_pulse, range_err, err_count, wrap_count, state);
  modport slave  (input en, cnt_in, clr, output locked, err_pulse, range_err, err_count, wrap_count, state);
endinterface

// File: rtl/mod_n_seq_checker.sv
// mod_n_seq_checker: checks a sampled counter bus follows 0..N-1,0 and keeps error/wrap statistics
module mod_n_seq_checker #(
  parameter int N          = 10,
  parameter int WIDTH      = 4,
  parameter int ERR_CNT_W  = 8,
  parameter int WRAP_CNT_W = 8
) (
  input logic                clk,
  input logic                rst,
  mod_n_seq_checker_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, TRACK = 2'd1, RESYNC = 2'd2} state_t;
  // N is compared one bit wider so N = 2**WIDTH stays representable
  localparam logic [WIDTH:0]   N_W     = (WIDTH+1)'(N);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(N - 1);
  localparam logic [WIDTH-1:0] EXP_ONE = (N == 1) ? '0 : WIDTH'(1);
  state_t                state_q, state_d;
  logic [WIDTH-1:0]      exp_q, exp_d;
  logic                  locked_q, locked_d, err_q, err_d, rng_q, rng_d, wrap_hit;
  logic [ERR_CNT_W-1:0]  errc_q, errc_d;
  logic [WRAP_CNT_W-1:0] wrapc_q, wrapc_d;
  logic                  in_range;
  assign in_range = {1'b0, bus.cnt_in} < N_W;
  always_comb begin
    state_d  = state_q;
    exp_d    = exp_q;
    locked_d = locked_q;
    err_d    = 1'b0;
    rng_d    = 1'b0;
    wrap_hit = 1'b0;
    if (bus.en) begin
      case (state_q)
        TRACK:
          if (!in_range || bus.cnt_in != exp_q) begin
            err_d    = 1'b1;
            rng_d    = !in_range;
            locked_d = 1'b0;
            state_d  = RESYNC;
          end else begin
            exp_d    = (exp_q == LAST) ? '0 : exp_q + 1'b1;
            wrap_hit = bus.cnt_in == '0;
            locked_d = locked_q | wrap_hit;
          end
        default:
          if (bus.cnt_in == '0) begin
            state_d = TRACK;
            exp_d   = EXP_ONE;
          end
      endcase
    end
    errc_d  = bus.clr ? '0 : (err_d && !(&errc_q)) ? errc_q + 1'b1 : errc_q;
    wrapc_d = bus.clr ? '0 : (wrap_hit && !(&wrapc_q)) ? wrapc_q + 1'b1 : wrapc_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      exp_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      rng_q    <= 1'b0;
      errc_q   <= '0;
      wrapc_q  <= '0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      rng_q    <= rng_d;
      errc_q   <= errc_d;
      wrapc_q  <= wrapc_d;
    end
  end
  assign bus.locked     = locked_q;
  assign bus.err_pulse  = err_q;
  assign bus.range_err  = rng_q;
  assign bus.err_count  = errc_q;
  assign bus.wrap_count = wrapc_q;
  assign bus.state      = state_q;
endmodule

// File: tb/tb_mod_n_seq_checker.sv
// tb_mod_n_seq_checker: directed vectors for the mod-10 sequence checker with a 2-bit error counter
module tb_mod_n_seq_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  int pulses = 0;
  mod_n_seq_checker_if #(.WIDTH(4), .ERR_CNT_W(2), .WRAP_CNT_W(8)) bus ();
  mod_n_seq_checker #(.N(10), .WIDTH(4), .ERR_CNT_W(2), .WRAP_CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask
  task automatic step(input logic e, input int c, input logic cl = 1'b0);
    bus.en = e;
    bus.cnt_in = 4'(c);
    bus.clr = cl;
    @(posedge clk);
    #1;
    if (bus.err_pulse) pulses++;
    bus.clr = 1'b0;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    bus.en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulses = 0;
  endtask
  initial begin
    bus.en = 1'b0;
    bus.cnt_in = '0;
    bus.clr = 1'b0;
    #1;
    chk("rst_state", bus.state, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_errc", bus.err_count, 0);
    chk("rst_wrapc", bus.wrap_count, 0);
    chk("rst_pulse", bus.err_pulse, 0);
    do_reset();
    // 1: clean period
    for (int i = 0; i <= 9; i++) step(1'b1, i);
    chk("t1_state", bus.state, 1);
    chk("t1_unlocked_at9", bus.locked, 0);
    step(1'b1, 0);
    chk("t1_locked", bus.locked, 1);
    chk("t1_wrapc", bus.wrap_count, 1);
    chk("t1_errc", bus.err_count, 0);
    chk("t1_pulses", pulses, 0);
    // 2: skipped value
    do_reset();
    step(1'b1, 0); step(1'b1, 1); step(1'b1, 2); step(1'b1, 4);
    chk("t2_pulse", bus.err_pulse, 1);
    chk("t2_range", bus.range_err, 0);
    chk("t2_errc", bus.err_count, 1);
    chk("t2_locked", bus.locked, 0);
    chk("t2_state", bus.state, 2);
    step(1'b1, 5);
    chk("t2_pulse_once", bus.err_pulse, 0);
    step(1'b1, 6);
    chk("t2_resync_quiet", bus.err_count, 1);
    step(1'b1, 0);
    chk("t2_retrack", bus.state, 1);
    for (int i = 1; i <= 9; i++) step(1'b1, i);
    chk("t2_unlocked_at9", bus.locked, 0);
    step(1'b1, 0);
    chk("t2_relock", bus.locked, 1);
    chk("t2_wrapc", bus.wrap_count, 1);
    chk("t2_pulses", pulses, 1);
    // 3: out-of-range sample
    step(1'b1, 12);
    chk("t3_pulse", bus.err_pulse, 1);
    chk("t3_range", bus.range_err, 1);
    chk("t3_errc", bus.err_count, 2);
    chk("t3_state", bus.state, 2);
    // 4: en gating
    do_reset();
    step(1'b1, 0); step(1'b1, 1); step(1'b1, 2);
    for (int i = 0; i < 5; i++) step(1'b0, 7);
    chk("t4_hold_state", bus.state, 1);
    chk("t4_hold_errc", bus.err_count, 0);
    step(1'b1, 3);
    chk("t4_state", bus.state, 1);
    chk("t4_pulse", bus.err_pulse, 0);
    chk("t4_pulses", pulses, 0);
    // 5: error counter saturation and clr on a wrap
    do_reset();
    step(1'b1, 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 5);
      step(1'b1, 0);
    end
    chk("t5_pulses", pulses, 5);
    chk("t5_errc_sat", bus.err_count, 3);
    for (int i = 1; i <= 9; i++) step(1'b1, i);
    step(1'b1, 0, 1'b1);
    chk("t5_clr_wrapc", bus.wrap_count, 0);
    chk("t5_clr_errc", bus.err_count, 0);
    chk("t5_clr_locked", bus.locked, 1);
    for (int i = 1; i <= 9; i++) step(1'b1, i);
    step(1'b1, 0);
    chk("t5_wrapc", bus.wrap_count, 1);
    // 6: async reset between edges, then stalled zero
    step(1'b1, 1);
    #3 rst = 1'b1;
    #1;
    chk("t6_async_state", bus.state, 0);
    chk("t6_async_locked", bus.locked, 0);
    chk("t6_async_wrapc", bus.wrap_count, 0);
    rst = 1'b0;
    pulses = 0;
    step(1'b1, 0);
    chk("t6_track", bus.state, 1);
    chk("t6_no_err", bus.err_pulse, 0);
    step(1'b1, 0);
    chk("t6_stall_pulse", bus.err_pulse, 1);
    chk("t6_stall_errc", bus.err_count, 1);
    chk("t6_stall_state", bus.state, 2);
    // clr coincident with an error: count clears, pulse still fires
    step(1'b1, 0);
    step(1'b1, 5, 1'b1);
    chk("clr_err_pulse", bus.err_pulse, 1);
    chk("clr_err_errc", bus.err_count, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
